vga_fb_dbuf: RTL
================

VGA_FB_DBUF -- requirements
Module: vga_fb_dbuf

Interface
REQ-001 SHALL have parameter H_BITS, default 10, horizontal pixel-index width.
REQ-002 SHALL have parameter V_BITS, default 9, vertical pixel-index width.
REQ-003 SHALL have parameter PIX_W, default 12, stored pixel width (1..16).
REQ-004 SHALL have parameters H_ACTIVE = 640 and V_ACTIVE = 480, the visible region.
REQ-005 SHALL have parameter DBL_BUF, default 1: 1 = two pages, 0 = single page.
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 sel  in  1  bus select.
REQ-009 we  in  1  bus write enable (with sel).
REQ-010 addr  in  32  bus byte address.
REQ-011 din  in  32  bus write data.
REQ-012 dout  out  32  bus read data, registered.
REQ-013 pix_en  in  1  pixel-clock enable strobe.
REQ-014 h_addr, v_addr  in  10 each  scan coordinates, sampled on pix_en.
REQ-015 frame_start  in  1  one-cycle strobe at vblank start.
REQ-016 vga_data  out  PIX_W  registered pixel to DAC.
REQ-017 flip_pending  out  1  flip requested, not yet taken.

Function
REQ-018 Pixel index SHALL be {h[H_BITS-1:0], v[V_BITS-1:0]}; bus pixel index SHALL be addr[H_BITS+V_BITS:1] (halfword addressing).
REQ-019 addr[20]=0 SHALL select pixel memory; addr[20]=1 SHALL select control register (addr[19:0] ignored).
REQ-020 Memory SHALL be PAGES x 2^(H_BITS+V_BITS) x PIX_W, PAGES = DBL_BUF ? 2 : 1; contents not reset.
REQ-021 Pixel write (sel & we, addr[20]=0) SHALL store din[PIX_W-1:0] into the back page (~front_page) at the next edge; DBL_BUF=0: page 0.
REQ-022 Pixel read (sel & ~we, addr[20]=0) SHALL present back-page pixel on dout one cycle later, zero-extended; dout SHALL hold until the next read.
REQ-023 Control write with din[0]=1 SHALL set flip_pending; din[0]=0 SHALL have no effect; DBL_BUF=0: ignored, flip_pending stays 0.
REQ-024 Control read SHALL return dout = {30'b0, flip_pending, front_page} one cycle later.
REQ-025 On frame_start with flip_pending=1, front_page SHALL toggle and flip_pending SHALL clear at the same edge.
REQ-026 Control write and frame_start in the same cycle: flip_pending SHALL set, no toggle; flip occurs at the next frame_start.
REQ-027 Repeated flip requests while pending SHALL coalesce into one flip.
REQ-028 Scan pipeline SHALL advance only on cycles with pix_en=1; stage 1 registers pixel index and in_range = (h_addr < H_ACTIVE) & (v_addr < V_ACTIVE); stage 2 registers the front-page word, or 0 if ~in_range, into vga_data.
REQ-029 vga_data SHALL reflect coordinates sampled on the pix_en two pix_en-cycles earlier; with pix_en=0, vga_data SHALL hold.
REQ-030 Scan SHALL read front_page as sampled at stage 1; a flip mid-pipeline SHALL not alter pixels already in stage 1.
REQ-031 Bus write and scan read of the same location in one cycle SHALL not conflict (different pages when DBL_BUF=1); DBL_BUF=0: scan returns old data.
REQ-032 Bus accesses SHALL complete in one cycle with no stall; no backpressure exists.

Reset
REQ-033 reset low SHALL asynchronously force front_page=0, flip_pending=0, vga_data=0, dout=0, pipeline in_range=0.
REQ-034 After reset deassertion, first valid vga_data SHALL appear after two pix_en cycles.
REQ-035 reset asserted mid-frame SHALL discard pending flip and in-flight pixels; memory contents SHALL be retained.

Verification
REQ-036 Write 0xABC to addr 0x00000002 (h=0,v=1), request flip, pulse frame_start, scan (0,1) -> vga_data=0xABC two pix_en later.
REQ-037 Write 0x123 to back page at (5,5), no flip, scan (5,5) -> vga_data = old front-page value, not 0x123.
REQ-038 Scan h_addr=640, v_addr=10 -> vga_data=0x000 regardless of memory.
REQ-039 Control write din=1 with frame_start same cycle -> flip_pending=1, front_page=0; next frame_start -> front_page=1, flip_pending=0; control read returns 0x1.
REQ-040 Assert reset with flip_pending=1 and front_page=1 -> control read after release returns 0x0, vga_data=0.
REQ-041 DBL_BUF=0: write 0x0F0 at (2,3), scan (2,3) -> 0x0F0; control write din=1 -> flip_pending stays 0.

Source files
------------

// File: rtl/vga_fb_dbuf.sv
// Double-buffered VGA frame buffer: bus side writes/reads the back page while the
// two-stage scan pipeline streams the front page; page swaps happen only at frame start.
module vga_fb_dbuf #(
    parameter int unsigned H_BITS   = 10,
    parameter int unsigned V_BITS   = 9,
    parameter int unsigned PIX_W    = 12,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned DBL_BUF  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      din_i,
    output logic [31:0]      dout_o,
    input  logic             pix_en_i,
    input  logic [9:0]       h_addr_i,
    input  logic [9:0]       v_addr_i,
    input  logic             frame_start_i,
    output logic [PIX_W-1:0] vga_data_o,
    output logic             flip_pending_o
);

    localparam int unsigned AW    = H_BITS + V_BITS;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PAGES = (DBL_BUF != 0) ? 2 : 1;
    localparam bit          DBL   = (DBL_BUF != 0);

    logic [PIX_W-1:0] mem_q [PAGES][DEPTH];

    logic             front_q, front_d;
    logic             flip_q, flip_d;
    logic [31:0]      dout_q, dout_d;
    logic [PIX_W-1:0] vga_q, vga_d;
    logic [AW-1:0]    s1_idx_q, s1_idx_d;
    logic             s1_inr_q, s1_inr_d;
    logic             s1_page_q, s1_page_d;

    logic [AW-1:0]    bus_idx_c;
    logic             is_ctrl_c;
    logic             back_page_c;
    logic             pix_wr_c;
    logic             flip_req_c;
    logic             unused_c;

    assign unused_c = ^{addr_i, din_i, h_addr_i, v_addr_i};

    // Next-state logic for bus port, flip control and scan pipeline.
    always_comb begin
        front_d     = front_q;
        flip_d      = flip_q;
        dout_d      = dout_q;
        vga_d       = vga_q;
        s1_idx_d    = s1_idx_q;
        s1_inr_d    = s1_inr_q;
        s1_page_d   = s1_page_q;

        bus_idx_c   = addr_i[AW:1];
        is_ctrl_c   = addr_i[20];
        back_page_c = DBL ? ~front_q : 1'b0;
        pix_wr_c    = sel_i && we_i && !is_ctrl_c;
        flip_req_c  = DBL && sel_i && we_i && is_ctrl_c && din_i[0];

        if (sel_i && !we_i) begin
            if (is_ctrl_c) dout_d = {30'b0, flip_q, front_q};
            else           dout_d = 32'(mem_q[back_page_c][bus_idx_c]);
        end

        // A request arriving with frame_start stays pending for the next frame.
        if (frame_start_i && flip_q) front_d = ~front_q;
        flip_d = flip_req_c || (flip_q && !frame_start_i);

        if (pix_en_i) begin
            s1_idx_d  = {h_addr_i[H_BITS-1:0], v_addr_i[V_BITS-1:0]};
            s1_inr_d  = (32'(h_addr_i) < H_ACTIVE) && (32'(v_addr_i) < V_ACTIVE);
            s1_page_d = front_q;
            vga_d     = s1_inr_q ? mem_q[s1_page_q][s1_idx_q] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q   <= 1'b0;
            flip_q    <= 1'b0;
            dout_q    <= '0;
            vga_q     <= '0;
            s1_idx_q  <= '0;
            s1_inr_q  <= 1'b0;
            s1_page_q <= 1'b0;
        end else begin
            front_q   <= front_d;
            flip_q    <= flip_d;
            dout_q    <= dout_d;
            vga_q     <= vga_d;
            s1_idx_q  <= s1_idx_d;
            s1_inr_q  <= s1_inr_d;
            s1_page_q <= s1_page_d;
        end
    end

    // Pixel storage survives reset.
    always_ff @(posedge clk) begin
        if (pix_wr_c) mem_q[back_page_c][bus_idx_c] <= din_i[PIX_W-1:0];
    end

    assign dout_o         = dout_q;
    assign vga_data_o     = vga_q;
    assign flip_pending_o = flip_q;

endmodule
